// File: rtl/ccd_frame_sequencer_if.sv
// Register-file side bundle of the CCD frame sequencer: program/start/stop controls,
// generator-facing drive lines and status pulses.
interface ccd_frame_sequencer_if #(
    parameter int PROG_DEPTH = 8,
    parameter int FRAME_W    = 16
);
    localparam int AW = $clog2(PROG_DEPTH);

    logic               i_start;
    logic               i_stop;
    logic               i_loop;
    logic [AW:0]        i_num_entries;
    logic               i_prog_we;
    logic [AW-1:0]      i_prog_addr;
    logic [3:0]         i_prog_data;
    logic               i_phi_p;
    logic               o_clk;
    logic               o_enable;
    logic               o_f_select_serial;
    logic               o_load_config;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic               o_prog_err;
    logic [FRAME_W-1:0] o_frame_cnt;

    modport master (
        output i_start, i_stop, i_loop, i_num_entries,
        output i_prog_we, i_prog_addr, i_prog_data, i_phi_p,
        input  o_clk, o_enable, o_f_select_serial, o_load_config,
        input  o_busy, o_done, o_err, o_prog_err, o_frame_cnt
    );

    modport slave (
        input  i_start, i_stop, i_loop, i_num_entries,
        input  i_prog_we, i_prog_addr, i_prog_data, i_phi_p,
        output o_clk, o_enable, o_f_select_serial, o_load_config,
        output o_busy, o_done, o_err, o_prog_err, o_frame_cnt
    );
endinterface

// File: rtl/ccd_frame_sequencer.sv
// Sequences 4-bit frequency codes into the CCD clock generator, one code per frame,
// using the returned phi_p falls as frame boundaries.
module ccd_frame_sequencer #(
    parameter int          CLK_DIV     = 4,
    parameter int          PROG_DEPTH  = 8,
    parameter int          FRAME_W     = 16,
    parameter int unsigned WDOG_CYCLES = 24'hFFFFFF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    ccd_frame_sequencer_if.slave  bus
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int NW = AW + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [3:0]         prog_mem [PROG_DEPTH];
    logic               phi_sync_p0, phi_sync_p1, phi_sync_p2;
    logic [DW-1:0]      div_cnt;
    logic [2:0]         bit_cnt;
    logic [AW-1:0]      idx;
    logic [NW-1:0]      num_q;
    logic               loop_q;
    logic [WW-1:0]      wdog_cnt;
    logic               clk_q, enable_q, serial_q, load_q;
    logic               done_q, err_q, prog_err_q;
    logic [FRAME_W-1:0] frame_q;

    logic               phi_fall, div_hit, fall_tick, last_entry, num_ok, wdog_hit, active;
    logic [AW-1:0]      idx_wrap;

    function automatic logic [FRAME_W-1:0] sat_inc_frame(input logic [FRAME_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + FRAME_W'(1);
    endfunction

    assign phi_fall   = phi_sync_p2 & ~phi_sync_p1;
    assign div_hit    = (div_cnt == DW'(CLK_DIV - 1));
    assign fall_tick  = clk_q & div_hit;
    assign last_entry = ({1'b0, idx} == num_q - NW'(1));
    assign idx_wrap   = last_entry ? '0 : idx + AW'(1);
    assign num_ok     = (bus.i_num_entries != '0) && (bus.i_num_entries <= NW'(PROG_DEPTH));
    assign wdog_hit   = (wdog_cnt == WW'(WDOG_CYCLES - 1));
    assign active     = (state == LOAD) || (state == RUN) || (state == DRAIN);

    // phi_p crosses in here: p0/p1 resolve metastability, p2 holds the previous sample
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            phi_sync_p0 <= 1'b0;
            phi_sync_p1 <= 1'b0;
            phi_sync_p2 <= 1'b0;
        end else begin
            phi_sync_p0 <= bus.i_phi_p;
            phi_sync_p1 <= phi_sync_p0;
            phi_sync_p2 <= phi_sync_p1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < PROG_DEPTH; i++) prog_mem[i] <= 4'd0;
        end else if (bus.i_prog_we && state == IDLE) begin
            prog_mem[bus.i_prog_addr] <= bus.i_prog_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            idx        <= '0;
            num_q      <= '0;
            loop_q     <= 1'b0;
            wdog_cnt   <= '0;
            clk_q      <= 1'b0;
            enable_q   <= 1'b0;
            serial_q   <= 1'b0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            prog_err_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            prog_err_q <= bus.i_prog_we && (state != IDLE);

            if (active) begin
                if (div_hit) begin
                    div_cnt <= '0;
                    clk_q   <= ~clk_q;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
                if (phi_fall) begin
                    frame_q  <= sat_inc_frame(frame_q);
                    wdog_cnt <= '0;
                end else begin
                    wdog_cnt <= wdog_cnt + WW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        if (num_ok) begin
                            loop_q   <= bus.i_loop;
                            num_q    <= bus.i_num_entries;
                            idx      <= '0;
                            frame_q  <= '0;
                            wdog_cnt <= '0;
                            enable_q <= 1'b1;
                            div_cnt  <= '0;
                            clk_q    <= 1'b0;
                            bit_cnt  <= '0;
                            load_q   <= 1'b1;
                            serial_q <= prog_mem[0][3];
                            state    <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Bits 2..0 follow falling ticks; the fifth tick ends the latch period
                    if (fall_tick) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        case (bit_cnt)
                            3'd0: serial_q <= prog_mem[idx][2];
                            3'd1: serial_q <= prog_mem[idx][1];
                            3'd2: serial_q <= prog_mem[idx][0];
                            3'd3: begin
                                load_q   <= 1'b0;
                                serial_q <= 1'b0;
                            end
                            default: state <= RUN;
                        endcase
                    end
                end
                RUN: begin
                    if (phi_fall) begin
                        if (last_entry && !loop_q) begin
                            state <= DRAIN;
                        end else begin
                            idx      <= idx_wrap;
                            div_cnt  <= '0;
                            clk_q    <= 1'b0;
                            bit_cnt  <= '0;
                            load_q   <= 1'b1;
                            serial_q <= prog_mem[idx_wrap][3];
                            state    <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (phi_fall) begin
                        done_q   <= 1'b1;
                        enable_q <= 1'b0;
                        clk_q    <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (active && wdog_hit && !phi_fall) begin
                err_q    <= 1'b1;
                enable_q <= 1'b0;
                clk_q    <= 1'b0;
                load_q   <= 1'b0;
                serial_q <= 1'b0;
                state    <= IDLE;
            end

            // Stop overrides completion and watchdog alike
            if (bus.i_stop && state != IDLE) begin
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                enable_q <= 1'b0;
                clk_q    <= 1'b0;
                load_q   <= 1'b0;
                serial_q <= 1'b0;
                state    <= IDLE;
            end
        end
    end

    assign bus.o_clk             = clk_q;
    assign bus.o_enable          = enable_q;
    assign bus.o_f_select_serial = serial_q;
    assign bus.o_load_config     = load_q;
    assign bus.o_busy            = (state != IDLE);
    assign bus.o_done            = done_q;
    assign bus.o_err             = err_q;
    assign bus.o_prog_err        = prog_err_q;
    assign bus.o_frame_cnt       = frame_q;
endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// Randomized bench for ccd_frame_sequencer: a generator model captures shifted codes
// and drives phi_p; expectations come from the program table and sequencing rules.
module tb_ccd_frame_sequencer;
    localparam int CLK_DIV    = 2;
    localparam int PROG_DEPTH = 8;
    localparam int FRAME_W    = 16;
    localparam int WDOG       = 100;
    localparam int LOAD_CYC   = 8 * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ccd_frame_sequencer_if #(.PROG_DEPTH(PROG_DEPTH), .FRAME_W(FRAME_W)) bus ();

    ccd_frame_sequencer #(
        .CLK_DIV(CLK_DIV), .PROG_DEPTH(PROG_DEPTH), .FRAME_W(FRAME_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] tbl [PROG_DEPTH];
    int         exp_frames;

    // Generator model: shifts serial on o_clk rising edges while load_config is high
    logic [3:0] loaded_q [$];
    int         done_cnt = 0, err_cnt = 0, perr_cnt = 0;
    logic       prev_clk = 1'b0, prev_load = 1'b0, load_abort = 1'b0;
    logic [3:0] sh = 4'd0;
    int         bits = 0, len = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_done)     done_cnt++;
            if (bus.o_err)      err_cnt++;
            if (bus.o_prog_err) perr_cnt++;
            if (bus.o_load_config && !prev_load) begin
                bits = 0;
                len = 0;
                load_abort = 1'b0;
            end
            if (bus.o_load_config) begin
                len++;
                if (bus.o_clk && !prev_clk) begin
                    sh = {sh[2:0], bus.o_f_select_serial};
                    bits++;
                end
                if (!rst_n) load_abort = 1'b1;
            end
            if (!bus.o_load_config && prev_load && !load_abort) begin
                check("load_len", len, LOAD_CYC);
                check("load_bits", bits, 4);
                loaded_q.push_back(sh);
            end
            prev_clk  = bus.o_clk;
            prev_load = bus.o_load_config;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input int addr, input logic [3:0] data);
        bus.i_prog_we   = 1'b1;
        bus.i_prog_addr = 3'(addr);
        bus.i_prog_data = data;
        step(1);
        bus.i_prog_we = 1'b0;
    endtask

    task automatic start_run(input int num, input logic lp);
        bus.i_num_entries = 4'(num);
        bus.i_loop        = lp;
        bus.i_start       = 1'b1;
        step(1);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_loads(input int n);
        int t = 0;
        while (loaded_q.size() < n && t < 400) begin
            step(1);
            t++;
        end
        check("load_seen", 32'(loaded_q.size() >= n), 1);
    endtask

    task automatic phi_pulse(input int high);
        bus.i_phi_p = 1'b1;
        step(high);
        bus.i_phi_p = 1'b0;
    endtask

    task automatic frames(input int nfalls, input int nloads);
        for (int i = 0; i < nfalls; i++) begin
            if (i < nloads) wait_loads(i + 1);
            step($urandom_range(8, 30));
            phi_pulse(4);
            exp_frames++;
            step(4);
            check("frame_cnt", bus.o_frame_cnt, exp_frames);
        end
    endtask

    task automatic run_once(input int num);
        int d0;
        loaded_q.delete();
        exp_frames = 0;
        d0 = done_cnt;
        start_run(num, 1'b0);
        frames(num + 1, num);
        check("done_pulse", done_cnt - d0, 1);
        check("busy_end", bus.o_busy, 0);
        check("enable_end", bus.o_enable, 0);
        check("n_loads", loaded_q.size(), num);
        for (int i = 0; i < num; i++)
            if (i < loaded_q.size()) check("code", loaded_q[i], tbl[i]);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_enable"}, bus.o_enable, 0);
        check({tag, "_clk"}, bus.o_clk, 0);
        check({tag, "_load"}, bus.o_load_config, 0);
        check({tag, "_serial"}, bus.o_f_select_serial, 0);
    endtask

    initial begin
        int d0, e0, p0, k;
        logic [3:0] init_codes [4];
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        bus.i_loop = 1'b0;
        bus.i_num_entries = '0;
        bus.i_prog_we = 1'b0;
        bus.i_prog_addr = '0;
        bus.i_prog_data = '0;
        bus.i_phi_p = 1'b0;
        for (int i = 0; i < PROG_DEPTH; i++) tbl[i] = 4'd0;

        step(3);
        check_quiet("rst");
        check("rst_done", bus.o_done, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_perr", bus.o_prog_err, 0);
        check("rst_frames", bus.o_frame_cnt, 0);
        rst_n = 1'b1;
        step(2);

        // Two-entry single pass over {3,5,A,F}
        init_codes = '{4'h3, 4'h5, 4'hA, 4'hF};
        p0 = perr_cnt;
        for (int i = 0; i < 4; i++) begin
            prog_write(i, init_codes[i]);
            tbl[i] = init_codes[i];
        end
        step(1);
        check("idle_write_no_perr", perr_cnt - p0, 0);
        run_once(2);

        // Looping over four entries, stopped after ten frames
        loaded_q.delete();
        exp_frames = 0;
        d0 = done_cnt;
        start_run(4, 1'b1);
        frames(10, 10);
        wait_loads(11);
        step(3);
        bus.i_stop = 1'b1;
        step(1);
        bus.i_stop = 1'b0;
        check_quiet("stop");
        step(3);
        check("stop_no_done", done_cnt - d0, 0);
        check("loop_frames", bus.o_frame_cnt, 10);
        check("loop_loads", loaded_q.size(), 11);
        for (int i = 0; i < 11; i++)
            if (i < loaded_q.size()) check("loop_code", loaded_q[i], tbl[i % 4]);

        // A fall during LOAD is counted but does not advance the entry
        loaded_q.delete();
        start_run(2, 1'b1);
        wait_loads(1);
        step($urandom_range(8, 30));
        phi_pulse(4);
        step(2);
        phi_pulse(3);
        wait_loads(2);
        step($urandom_range(8, 30));
        phi_pulse(4);
        wait_loads(3);
        step(2);
        check("load_fall_frames", bus.o_frame_cnt, 3);
        bus.i_stop = 1'b1;
        step(1);
        bus.i_stop = 1'b0;
        check("lf_code0", loaded_q[0], tbl[0]);
        check("lf_code1", loaded_q[1], tbl[1]);
        check("lf_code2", loaded_q[2], tbl[0]);

        // Program write while busy is rejected
        p0 = perr_cnt;
        loaded_q.delete();
        exp_frames = 0;
        start_run(1, 1'b0);
        step(5);
        prog_write(0, ~tbl[0]);
        step(2);
        check("perr_pulse", perr_cnt - p0, 1);
        frames(2, 1);
        run_once(1);

        // Randomized single-pass runs
        for (int it = 0; it < 3; it++) begin
            int num;
            for (int i = 0; i < PROG_DEPTH; i++) begin
                tbl[i] = 4'($urandom_range(0, 15));
                prog_write(i, tbl[i]);
            end
            num = (it == 0) ? PROG_DEPTH : int'($urandom_range(1, PROG_DEPTH));
            run_once(num);
        end

        // Watchdog without any phi_p activity
        loaded_q.delete();
        e0 = err_cnt;
        start_run(3, 1'b0);
        k = 0;
        while (!bus.o_err && k < 300) begin
            step(1);
            k++;
        end
        check("wdog_cycles", k, WDOG);
        check_quiet("wdog");
        step(1);
        check("wdog_err_pulse", err_cnt - e0, 1);
        check("wdog_err_low", bus.o_err, 0);

        // Illegal entry counts and start together with stop
        e0 = err_cnt;
        start_run(0, 1'b0);
        step(1);
        check("num0_err", err_cnt - e0, 1);
        check("num0_busy", bus.o_busy, 0);
        start_run(PROG_DEPTH + 1, 1'b0);
        step(1);
        check("num9_err", err_cnt - e0, 2);
        check("num9_busy", bus.o_busy, 0);
        bus.i_stop = 1'b1;
        start_run(2, 1'b0);
        bus.i_stop = 1'b0;
        step(1);
        check("start_stop_busy", bus.o_busy, 0);
        check("start_stop_err", err_cnt - e0, 2);

        // Reset in the middle of LOAD clears outputs and the table
        for (int i = 0; i < PROG_DEPTH; i++) begin
            tbl[i] = 4'($urandom_range(1, 15));
            prog_write(i, tbl[i]);
        end
        start_run(2, 1'b0);
        step(7);
        check("pre_rst_load", bus.o_load_config, 1);
        rst_n = 1'b0;
        step(1);
        check_quiet("midrst");
        check("midrst_frames", bus.o_frame_cnt, 0);
        rst_n = 1'b1;
        for (int i = 0; i < PROG_DEPTH; i++) tbl[i] = 4'd0;
        step(2);
        run_once(PROG_DEPTH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
